// File: rtl/mem_stage.sv
// mem_stage: memory stage of an RV32I pipeline.
// Decodes loads and stores coming out of the EX/MEM register and issues one
// data-memory request per access, holding it until dm_ack. It stalls
// upstream while the access is outstanding and feeds the MEM/WB register.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   M_*                     instruction currently in the EX/MEM register
//   dm_req/addr/we/wdata    registered data-memory request
//   dm_ack, dm_rdata        data-memory completion and read word
//   mem_stall               hold upstream stages (combinational)
//   W_*, LD_data            registered MEM/WB outputs
//   misalign_exc            one-cycle pulse for a misaligned access
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_valid,
  input  logic        M_mem_read,
  input  logic        M_mem_write,
  input  logic [2:0]  M_funct3,
  input  logic [31:0] M_alu_out,
  input  logic [31:0] M_rs2_data,
  input  logic [4:0]  M_rd,
  input  logic        M_reg_write,
  input  logic        M_wb_data_select,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        W_valid,
  output logic [4:0]  W_rd,
  output logic        W_reg_write,
  output logic        W_wb_data_select,
  output logic [2:0]  W_funct3,
  output logic [31:0] W_alu_out,
  output logic [31:0] LD_data,
  output logic        misalign_exc
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  logic        state_q, state_d;
  logic        dm_req_q, dm_req_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [3:0]  dm_we_q, dm_we_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic        w_valid_q, w_valid_d;
  logic [4:0]  w_rd_q, w_rd_d;
  logic        w_reg_write_q, w_reg_write_d;
  logic        w_wbsel_q, w_wbsel_d;
  logic [2:0]  w_funct3_q, w_funct3_d;
  logic [31:0] w_alu_out_q, w_alu_out_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        misalign_exc_q, misalign_exc_d;

  // Captured instruction; upstream may only be trusted through these while BUSY.
  logic [4:0]  cap_rd_q, cap_rd_d;
  logic        cap_reg_write_q, cap_reg_write_d;
  logic        cap_wbsel_q, cap_wbsel_d;
  logic [2:0]  cap_funct3_q, cap_funct3_d;
  logic [31:0] cap_alu_out_q, cap_alu_out_d;
  logic        cap_load_q, cap_load_d;

  logic        access;
  logic        misaligned;
  logic [1:0]  off;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;

  assign access = M_valid & (M_mem_read | M_mem_write);
  assign off    = M_alu_out[1:0];

  always_comb begin
    misaligned = 1'b0;
    st_we      = 4'b1111;
    st_wdata   = M_rs2_data;
    case (M_funct3[1:0])
      2'b00: begin
        st_we    = 4'b0001 << off;
        st_wdata = {4{M_rs2_data[7:0]}};
      end
      2'b01: begin
        misaligned = off[0];
        st_we      = 4'b0011 << off;
        st_wdata   = {2{M_rs2_data[15:0]}};
      end
      2'b10: misaligned = (off != 2'b00);
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (access && !misaligned) state_d = S_BUSY;
      S_BUSY: if (dm_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    dm_req_d        = dm_req_q;
    dm_addr_d       = dm_addr_q;
    dm_we_d         = dm_we_q;
    dm_wdata_d      = dm_wdata_q;
    w_valid_d       = w_valid_q;
    w_rd_d          = w_rd_q;
    w_reg_write_d   = w_reg_write_q;
    w_wbsel_d       = w_wbsel_q;
    w_funct3_d      = w_funct3_q;
    w_alu_out_d     = w_alu_out_q;
    ld_data_d       = ld_data_q;
    misalign_exc_d  = 1'b0;
    cap_rd_d        = cap_rd_q;
    cap_reg_write_d = cap_reg_write_q;
    cap_wbsel_d     = cap_wbsel_q;
    cap_funct3_d    = cap_funct3_q;
    cap_alu_out_d   = cap_alu_out_q;
    cap_load_d      = cap_load_q;
    mem_stall       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && !misaligned) begin
          mem_stall       = 1'b1;
          dm_req_d        = 1'b1;
          dm_addr_d       = {M_alu_out[31:2], 2'b00};
          dm_we_d         = M_mem_write ? st_we : 4'b0000;
          dm_wdata_d      = st_wdata;
          w_valid_d       = 1'b0;
          cap_rd_d        = M_rd;
          cap_reg_write_d = M_reg_write & M_mem_read;
          cap_wbsel_d     = M_wb_data_select;
          cap_funct3_d    = M_funct3;
          cap_alu_out_d   = M_alu_out;
          cap_load_d      = M_mem_read;
        end else begin
          // Reaching here with access set means the access was misaligned.
          w_valid_d      = M_valid;
          w_rd_d         = M_rd;
          w_reg_write_d  = M_reg_write & ~access;
          w_wbsel_d      = M_wb_data_select;
          w_funct3_d     = M_funct3;
          w_alu_out_d    = M_alu_out;
          misalign_exc_d = access;
        end
      end
      S_BUSY: begin
        if (dm_ack) begin
          dm_req_d      = 1'b0;
          w_valid_d     = 1'b1;
          w_rd_d        = cap_rd_q;
          w_reg_write_d = cap_reg_write_q;
          w_wbsel_d     = cap_wbsel_q;
          w_funct3_d    = cap_funct3_q;
          w_alu_out_d   = cap_alu_out_q;
          // Raw lane-aligned load data; extension happens in writeback.
          if (cap_load_q) ld_data_d = dm_rdata >> {cap_alu_out_q[1:0], 3'b000};
        end else begin
          mem_stall = 1'b1;
          w_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (!rst_n) mem_stall = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      dm_req_q       <= 1'b0;
      dm_addr_q      <= '0;
      dm_we_q        <= '0;
      dm_wdata_q     <= '0;
      w_valid_q      <= 1'b0;
      w_rd_q         <= '0;
      w_reg_write_q  <= 1'b0;
      w_wbsel_q      <= 1'b0;
      w_funct3_q     <= '0;
      w_alu_out_q    <= '0;
      ld_data_q      <= '0;
      misalign_exc_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dm_req_q       <= dm_req_d;
      dm_addr_q      <= dm_addr_d;
      dm_we_q        <= dm_we_d;
      dm_wdata_q     <= dm_wdata_d;
      w_valid_q      <= w_valid_d;
      w_rd_q         <= w_rd_d;
      w_reg_write_q  <= w_reg_write_d;
      w_wbsel_q      <= w_wbsel_d;
      w_funct3_q     <= w_funct3_d;
      w_alu_out_q    <= w_alu_out_d;
      ld_data_q      <= ld_data_d;
      misalign_exc_q <= misalign_exc_d;
    end
  end

  // Captured copies are pure data and need no reset.
  always_ff @(posedge clk) begin
    cap_rd_q        <= cap_rd_d;
    cap_reg_write_q <= cap_reg_write_d;
    cap_wbsel_q     <= cap_wbsel_d;
    cap_funct3_q    <= cap_funct3_d;
    cap_alu_out_q   <= cap_alu_out_d;
    cap_load_q      <= cap_load_d;
  end

  assign dm_req           = dm_req_q;
  assign dm_addr          = dm_addr_q;
  assign dm_we            = dm_we_q;
  assign dm_wdata         = dm_wdata_q;
  assign W_valid          = w_valid_q;
  assign W_rd             = w_rd_q;
  assign W_reg_write      = w_reg_write_q;
  assign W_wb_data_select = w_wbsel_q;
  assign W_funct3         = w_funct3_q;
  assign W_alu_out        = w_alu_out_q;
  assign LD_data          = ld_data_q;
  assign misalign_exc     = misalign_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        M_valid, M_mem_read, M_mem_write;
  logic [2:0]  M_funct3;
  logic [31:0] M_alu_out, M_rs2_data;
  logic [4:0]  M_rd;
  logic        M_reg_write, M_wb_data_select;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_we;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_stall;
  logic        W_valid;
  logic [4:0]  W_rd;
  logic        W_reg_write, W_wb_data_select;
  logic [2:0]  W_funct3;
  logic [31:0] W_alu_out, LD_data;
  logic        misalign_exc;

  int checks = 0;
  int errors = 0;

  // Reference state: word memory and last loaded value.
  logic [31:0] mem [256];
  logic [31:0] ld_model;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .M_valid(M_valid), .M_mem_read(M_mem_read), .M_mem_write(M_mem_write),
    .M_funct3(M_funct3), .M_alu_out(M_alu_out), .M_rs2_data(M_rs2_data),
    .M_rd(M_rd), .M_reg_write(M_reg_write), .M_wb_data_select(M_wb_data_select),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .mem_stall(mem_stall),
    .W_valid(W_valid), .W_rd(W_rd), .W_reg_write(W_reg_write),
    .W_wb_data_select(W_wb_data_select), .W_funct3(W_funct3),
    .W_alu_out(W_alu_out), .LD_data(LD_data), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    M_valid     = 1'b0;
    M_mem_read  = 1'b0;
    M_mem_write = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-memory instruction: passes straight to W in one cycle.
  task automatic do_alu(input logic [4:0] rd, input logic [31:0] val,
                        input logic rw, input logic wbsel);
    M_valid = 1'b1; M_mem_read = 1'b0; M_mem_write = 1'b0;
    M_funct3 = 3'($urandom); M_alu_out = val; M_rs2_data = $urandom;
    M_rd = rd; M_reg_write = rw; M_wb_data_select = wbsel;
    #1 check("alu_stall", 32'(mem_stall), 32'd0);
    tick();
    idle_inputs();
    check("alu_wvalid", 32'(W_valid), 32'd1);
    check("alu_wrd", 32'(W_rd), 32'(rd));
    check("alu_wout", W_alu_out, val);
    check("alu_wrw", 32'(W_reg_write), 32'(rw));
    check("alu_wsel", 32'(W_wb_data_select), 32'(wbsel));
    check("alu_req", 32'(dm_req), 32'd0);
    check("alu_exc", 32'(misalign_exc), 32'd0);
    check("alu_ld", LD_data, ld_model);
  endtask

  // Load or store, with `waits` ack-less BUSY cycles before the ack.
  task automatic do_mem(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic rw,
                        input int waits);
    int n, o, idx;
    bit mis;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd, word, exp_ld;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    o   = int'(addr % 4);
    mis = (addr % n) != 0;
    idx = int'(addr[9:2]);
    exp_we = 4'b0000;
    exp_wd = '0;
    for (int i = 0; i < 4; i++) begin
      if (!is_load && i >= o && i < o + n) exp_we[i] = 1'b1;
      exp_wd[8*i +: 8] = rs2[8*(i % n) +: 8];
    end
    M_valid = 1'b1; M_mem_read = is_load; M_mem_write = !is_load;
    M_funct3 = f3; M_alu_out = addr; M_rs2_data = rs2; M_rd = rd;
    M_reg_write = rw; M_wb_data_select = is_load;
    #1 check("mem_stall_first", 32'(mem_stall), 32'(!mis));
    if (mis) begin
      tick();
      idle_inputs();
      check("mis_req", 32'(dm_req), 32'd0);
      check("mis_exc", 32'(misalign_exc), 32'd1);
      check("mis_wvalid", 32'(W_valid), 32'd1);
      check("mis_wrw", 32'(W_reg_write), 32'd0);
      check("mis_wout", W_alu_out, addr);
      #1 check("mis_stall_after", 32'(mem_stall), 32'd0);
      tick();
      check("mis_exc_pulse", 32'(misalign_exc), 32'd0);
      check("mis_req2", 32'(dm_req), 32'd0);
      return;
    end
    tick();
    check("req_on", 32'(dm_req), 32'd1);
    check("req_addr", dm_addr, addr & 32'hFFFF_FFFC);
    check("req_we", 32'(dm_we), 32'(exp_we));
    if (!is_load) check("req_wdata", dm_wdata, exp_wd);
    check("req_bubble", 32'(W_valid), 32'd0);
    for (int w = 0; w < waits; w++) begin
      dm_ack = 1'b0;
      dm_rdata = $urandom;
      #1 check("wait_stall", 32'(mem_stall), 32'd1);
      tick();
      check("wait_req", 32'(dm_req), 32'd1);
      check("wait_addr", dm_addr, addr & 32'hFFFF_FFFC);
      check("wait_we", 32'(dm_we), 32'(exp_we));
      check("wait_bubble", 32'(W_valid), 32'd0);
    end
    word = mem[idx];
    dm_ack = 1'b1;
    dm_rdata = word;
    #1 check("ack_stall", 32'(mem_stall), 32'd0);
    if (is_load) begin
      exp_ld = '0;
      for (int k = 0; k < 4; k++)
        if (k + o < 4) exp_ld[8*k +: 8] = word[8*(k+o) +: 8];
      ld_model = exp_ld;
    end else begin
      for (int i = 0; i < 4; i++)
        if (exp_we[i]) mem[idx][8*i +: 8] = exp_wd[8*i +: 8];
    end
    tick();
    dm_ack = 1'b0;
    dm_rdata = $urandom;
    idle_inputs();
    check("done_wvalid", 32'(W_valid), 32'd1);
    check("done_wrd", 32'(W_rd), 32'(rd));
    check("done_wrw", 32'(W_reg_write), 32'(is_load ? rw : 1'b0));
    check("done_wout", W_alu_out, addr);
    check("done_f3", 32'(W_funct3), 32'(f3));
    check("done_ld", LD_data, ld_model);
    check("done_req_off", 32'(dm_req), 32'd0);
    check("done_exc", 32'(misalign_exc), 32'd0);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    ld_model = '0;
    rst_n = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    idle_inputs();
    M_funct3 = '0; M_alu_out = '0; M_rs2_data = '0; M_rd = '0;
    M_reg_write = 1'b0; M_wb_data_select = 1'b0;
    tick(); tick();
    check("rst_req", 32'(dm_req), 32'd0);
    check("rst_we", 32'(dm_we), 32'd0);
    check("rst_addr", dm_addr, 32'd0);
    check("rst_wvalid", 32'(W_valid), 32'd0);
    check("rst_wout", W_alu_out, 32'd0);
    check("rst_ld", LD_data, 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU result passes through
    do_alu(5'd5, 32'h1234, 1'b1, 1'b0);
    // LBU with three wait cycles
    mem[int'(10'h003 >> 2)] = 32'hAB00_0000;
    do_mem(1'b1, 3'b100, 32'h1003, 32'h0, 5'd7, 1'b1, 3);
    check("lbu_value", LD_data, 32'h0000_00AB);
    // SH, acked in the first BUSY cycle
    do_mem(1'b0, 3'b001, 32'h2002, 32'hDEAD_BEEF, 5'd3, 1'b1, 0);
    // Misaligned LW
    do_mem(1'b1, 3'b010, 32'h3001, 32'h0, 5'd9, 1'b1, 0);
    // Back-to-back SW then LW at the same address
    do_mem(1'b0, 3'b010, 32'h10, 32'hCAFE_F00D, 5'd1, 1'b1, 1);
    do_mem(1'b1, 3'b010, 32'h10, 32'h0, 5'd2, 1'b1, 0);
    check("sw_lw_value", LD_data, 32'hCAFE_F00D);

    // Ack in IDLE is ignored
    dm_ack = 1'b1;
    #1 check("idle_ack_stall", 32'(mem_stall), 32'd0);
    tick();
    dm_ack = 1'b0;
    check("idle_ack_wvalid", 32'(W_valid), 32'd0);
    check("idle_ack_req", 32'(dm_req), 32'd0);

    // Reset while BUSY, then a late ack
    M_valid = 1'b1; M_mem_read = 1'b1; M_mem_write = 1'b0;
    M_funct3 = 3'b010; M_alu_out = 32'h40; M_rd = 5'd4; M_reg_write = 1'b1;
    tick();
    check("busy_req", 32'(dm_req), 32'd1);
    rst_n = 1'b0;
    #1 check("rst_busy_stall", 32'(mem_stall), 32'd0);
    tick();
    ld_model = '0;
    idle_inputs();
    check("rstb_req", 32'(dm_req), 32'd0);
    check("rstb_wvalid", 32'(W_valid), 32'd0);
    check("rstb_addr", dm_addr, 32'd0);
    check("rstb_ld", LD_data, 32'd0);
    rst_n = 1'b1;
    dm_ack = 1'b1;
    #1 check("late_ack_stall", 32'(mem_stall), 32'd0);
    tick();
    dm_ack = 1'b0;
    check("late_ack_wvalid", 32'(W_valid), 32'd0);
    check("late_ack_req", 32'(dm_req), 32'd0);

    // Randomized mix
    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_alu(5'($urandom), $urandom, 1'($urandom), 1'($urandom));
        1: do_mem(1'b1, ld_f3[$urandom_range(0, 4)], $urandom, $urandom,
                  5'($urandom), 1'($urandom), $urandom_range(0, 3));
        2: do_mem(1'b0, 3'($urandom_range(0, 2)), $urandom, $urandom,
                  5'($urandom), 1'($urandom), $urandom_range(0, 3));
        default: begin
          // Memory flags with no valid instruction: not an access
          M_valid = 1'b0; M_mem_read = 1'($urandom); M_mem_write = ~M_mem_read;
          M_alu_out = $urandom;
          #1 check("nv_stall", 32'(mem_stall), 32'd0);
          tick();
          idle_inputs();
          check("nv_wvalid", 32'(W_valid), 32'd0);
          check("nv_req", 32'(dm_req), 32'd0);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all datapaths SHALL be 32 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 M_valid  in  1  instruction present in the EX/MEM register.
REQ-005 M_mem_read, M_mem_write  in  1 each  load or store instruction; they are never both high.
REQ-006 M_funct3  in  3  RV32I load/store width code.
REQ-007 M_alu_out  in  32  effective address, or ALU result for non-memory instructions.
REQ-008 M_rs2_data  in  32  store source data.
REQ-009 M_rd  in  5;  M_reg_write  in  1;  M_wb_data_select  in  1  writeback control.
REQ-010 dm_req  out  1;  dm_addr  out  32;  dm_we  out  4;  dm_wdata  out  32  data-memory request.
REQ-011 dm_ack  in  1;  dm_rdata  in  32  data-memory completion and read data.
REQ-012 mem_stall  out  1  hold all upstream stages.
REQ-013 Pipeline-register outputs, all registered:
- W_valid  out  1
- W_rd  out  5
- W_reg_write  out  1
- W_wb_data_select  out  1
- W_funct3  out  3
- W_alu_out  out  32
- LD_data  out  32
REQ-014 misalign_exc  out  1  one-cycle registered pulse flagging a misaligned access.

Function
REQ-015 FSM states SHALL be IDLE and BUSY; state, all dm_* outputs and all W_* registers SHALL be implemented as flops.
REQ-016 An access is M_valid & (M_mem_read | M_mem_write).
REQ-017 An access is misaligned when:
- M_funct3[1:0]=2'b10 and addr[1:0]!=0, or
- M_funct3[1:0]=2'b01 and addr[0]=1.
REQ-018 IDLE, non-access: the W registers SHALL load from the M inputs at the next edge, with mem_stall=0.
REQ-019 IDLE, aligned access:
- mem_stall=1 combinationally in the same cycle.
- Address, strobes and data SHALL be captured into dm_addr/dm_we/dm_wdata.
- The FSM SHALL go to BUSY.
- W_valid SHALL load 0 (bubble).
REQ-020 IDLE, misaligned access:
- No dm_req SHALL be issued and mem_stall=0.
- At the next edge W_valid=1, W_reg_write=0, and misalign_exc=1 for one cycle.
REQ-021 BUSY: dm_req=1, and dm_addr/dm_we/dm_wdata SHALL stay stable until dm_ack.
REQ-022 BUSY with dm_ack=0: mem_stall=1 and W_valid SHALL load 0.
REQ-023 BUSY with dm_ack=1:
- mem_stall=0 in that cycle.
- At the edge: W registers load the captured instruction, W_valid=1, and the FSM returns to IDLE.
- dm_req SHALL be 0 in the following cycle.
REQ-024 Minimum access latency SHALL be 2 cycles (request cycle + ack cycle); there is no upper bound and no timeout.
REQ-025 dm_addr SHALL be {addr[31:2],2'b00}.
REQ-026 Load: dm_we=4'b0000; at ack, LD_data = dm_rdata >> (8*addr[1:0]).
- Sign/zero extension is the writeback stage's job, not this block's.
REQ-027 Store byte (SB): dm_we = 4'b0001<<addr[1:0]; dm_wdata = {4{rs2[7:0]}}.
REQ-028 Store halfword (SH): dm_we = 4'b0011<<addr[1:0]; dm_wdata = {2{rs2[15:0]}}.
REQ-029 Store word (SW): dm_we = 4'b1111; dm_wdata = rs2.
REQ-030 Stores SHALL write W_reg_write=0 regardless of M_reg_write.
REQ-031 dm_ack while in IDLE SHALL be ignored.
REQ-032 Upstream holds the M inputs stable while mem_stall=1; this block SHALL use only its captured copies while BUSY.

Reset
REQ-033 When rst_n=0 at a rising edge, the following SHALL be cleared at that edge, including mid-transaction:
- state=IDLE
- dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0
- W_valid=0, W_reg_write=0, W_rd=0, W_wb_data_select=0, W_funct3=0, W_alu_out=0, LD_data=0
- misalign_exc=0
REQ-034 While rst_n=0, mem_stall SHALL be 0.
REQ-035 An outstanding dm_ack arriving after reset SHALL be ignored.

Verification
REQ-036 ALU instruction, rd=5, alu_out=0x1234 -> next cycle W_valid=1, W_rd=5, W_alu_out=0x1234, mem_stall never 1.
REQ-037 LBU at 0x1003, dm_rdata=0xAB000000, ack after 3 wait cycles:
- mem_stall=1 for 4 cycles.
- dm_addr=0x1000.
- Then LD_data=0x000000AB, W_valid=1.
REQ-038 SH at 0x2002, rs2=0xDEADBEEF, ack in first BUSY cycle -> dm_we=4'b1100, dm_wdata=0xBEEFBEEF, W_reg_write=0, 2-cycle latency.
REQ-039 LW at 0x3001 -> no dm_req, misalign_exc pulses once, W_reg_write=0, mem_stall=0.
REQ-040 rst_n=0 while BUSY -> next cycle dm_req=0, W_valid=0, state IDLE; late dm_ack produces no W_valid.
REQ-041 Back-to-back SW 0x10 then LW 0x10 -> second request issues only after the first ack; no cycle has dm_req high in IDLE.
